uart_tx_arbiter: RTL

Shares the single UART transmitter between two byte sources: requester 0 (CPU store path into the TX data register) and requester 1 (hardware trap/debug message source). It sits between those requesters and the transmitter's `tx_en`/`data_in`/`done` port. It arbitrates round-robin, latches the winning byte, and holds `tx_en` for the whole frame. It enforces an inter-frame gap and times out a hung transmitter.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_rr_arb2.sv | 20 ++
 rtl/uart_tx_arbiter.sv | 107 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART TX arbiter slice
package uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEND,
      ST_GAP
   } state_t;

   localparam logic REQ_CPU = 1'b0;
   localparam logic REQ_DBG = 1'b1;

   localparam int CNT_W = 16;

endpackage

// File: rtl/uart_rr_arb2.sv
// rtl/uart_rr_arb2.sv - two-way round-robin grant, purely combinational
module uart_rr_arb2
   import uart_pkg::*;
(
   input  logic [1:0] valid,
   input  logic       rr_ptr,
   input  logic       en,
   output logic [1:0] gnt,
   output logic       gnt_id
);

   // rr_ptr only matters on contention; a lone requester always wins
   always_comb begin
      gnt_id = (valid == 2'b11) ? rr_ptr : valid[1];
      gnt    = 2'b00;
      if (en && (valid != 2'b00))
         gnt = (gnt_id == REQ_DBG) ? 2'b10 : 2'b01;
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - shares one UART transmitter between CPU and debug byte sources
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int GAP_CYCLES     = 2,
   parameter int TIMEOUT_CYCLES = 20000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0_valid,
   input  logic [7:0] req0_data,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [7:0] req1_data,
   output logic       req1_ready,
   output logic       tx_en,
   output logic [7:0] tx_data,
   input  logic       tx_done,
   output logic       busy,
   output logic       grant_id,
   output logic       sent,
   output logic       timeout_err,
   input  logic       err_clr
);

   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             rr_ptr;
   logic [1:0]       gnt;
   logic             gnt_id;

   uart_rr_arb2 u_arb (
      .valid  ({req1_valid, req0_valid}),
      .rr_ptr (rr_ptr),
      .en     (state == ST_IDLE),
      .gnt    (gnt),
      .gnt_id (gnt_id)
   );

   assign req0_ready = gnt[0];
   assign req1_ready = gnt[1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         rr_ptr      <= REQ_CPU;
         tx_en       <= 1'b0;
         tx_data     <= 8'h00;
         grant_id    <= REQ_CPU;
         busy        <= 1'b0;
         sent        <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         sent <= 1'b0;
         // A timeout assignment later in this block overrides the clear
         if (err_clr)
            timeout_err <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (gnt != 2'b00) begin
                  tx_data  <= (gnt_id == REQ_DBG) ? req1_data : req0_data;
                  grant_id <= gnt_id;
                  rr_ptr   <= ~gnt_id;
                  cnt      <= '0;
                  tx_en    <= 1'b1;
                  busy     <= 1'b1;
                  state    <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (tx_done) begin
                  sent  <= 1'b1;
                  cnt   <= '0;
                  tx_en <= 1'b0;
                  state <= ST_GAP;
               end else if (cnt == TO_LAST) begin
                  timeout_err <= 1'b1;
                  cnt         <= '0;
                  tx_en       <= 1'b0;
                  state       <= ST_GAP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_GAP: begin
               if (cnt == GAP_LAST) begin
                  cnt   <= '0;
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               tx_en <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
